// File: rtl/sc_spi_xfer_ctrl_if.sv
// rtl/sc_spi_xfer_ctrl_if.sv - host and engine signal bundle for the SPI transfer controller
//
// Host side : TXWE/TXWADDR/TXWDATA (TX fill), RXRADDR/RXRDATA/RXCNT (RX readback),
//             CMDSTART/CMDBUSY/CMDDONE/CMDERR/DONECLR/TOUTVAL (command control).
// Engine side: SPISTART/SPIBUSY (start handshake), TXDPT/TXDATA (TX word fetch),
//             RXDATA/RXVALID/RXDPT (RX word capture).
// slave modport is the controller; master modport is whatever drives host and engine.
interface sc_spi_xfer_ctrl_if #(
  parameter int TOUT_WIDTH = 16
);
  logic                  TXWE;
  logic [3:0]            TXWADDR;
  logic [31:0]           TXWDATA;
  logic [3:0]            RXRADDR;
  logic [31:0]           RXRDATA;
  logic [4:0]            RXCNT;
  logic                  CMDSTART;
  logic                  CMDBUSY;
  logic                  CMDDONE;
  logic                  CMDERR;
  logic                  DONECLR;
  logic [TOUT_WIDTH-1:0] TOUTVAL;
  logic                  SPISTART;
  logic                  SPIBUSY;
  logic [3:0]            TXDPT;
  logic [31:0]           TXDATA;
  logic [31:0]           RXDATA;
  logic                  RXVALID;
  logic [3:0]            RXDPT;

  modport slave (
    input  TXWE, TXWADDR, TXWDATA, RXRADDR, CMDSTART, DONECLR, TOUTVAL,
    input  SPIBUSY, TXDPT, RXDATA, RXVALID, RXDPT,
    output RXRDATA, RXCNT, CMDBUSY, CMDDONE, CMDERR, SPISTART, TXDATA
  );

  modport master (
    output TXWE, TXWADDR, TXWDATA, RXRADDR, CMDSTART, DONECLR, TOUTVAL,
    output SPIBUSY, TXDPT, RXDATA, RXVALID, RXDPT,
    input  RXRDATA, RXCNT, CMDBUSY, CMDDONE, CMDERR, SPISTART, TXDATA
  );
endinterface

// File: rtl/sc_spi_xfer_ctrl.sv
// rtl/sc_spi_xfer_ctrl.sv - SPI transfer controller with TX/RX word buffers and busy watchdog
//
// Ports: SPICLK (rising-edge clock), SYSRSTB (async active-low reset),
//        bus (sc_spi_xfer_ctrl_if.slave: host buffer/command signals and engine handshake).
module sc_spi_xfer_ctrl #(
  parameter int TOUT_WIDTH = 16
) (
  input  logic                  SPICLK,
  input  logic                  SYSRSTB,
  sc_spi_xfer_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, REQ, RUN} state_t;

  state_t                state, state_nxt;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  start_q, start_d;
  logic [TOUT_WIDTH-1:0] wdog_q, wdog_d;
  logic [4:0]            rxcnt_q, rxcnt_d;
  logic [31:0]           rxrdata_q;
  logic [31:0]           txbuf [16];
  logic [31:0]           rxbuf [16];
  logic                  wd_hit;

  // A zero limit disables the watchdog; otherwise it fires on the cycle the
  // counter reaches TOUTVAL-1, so SPISTART/busy last exactly TOUTVAL cycles.
  assign wd_hit = (bus.TOUTVAL != '0) && (wdog_q == bus.TOUTVAL - TOUT_WIDTH'(1));

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      wdog_q  <= '0;
      rxcnt_q <= '0;
    end else begin
      state   <= state_nxt;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      wdog_q  <= wdog_d;
      rxcnt_q <= rxcnt_d;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_d    = busy_q;
    // Clear first; any set event below overrides it in the same cycle.
    done_d    = done_q & ~bus.DONECLR;
    err_d     = err_q & ~bus.DONECLR;
    start_d   = start_q;
    wdog_d    = wdog_q;
    rxcnt_d   = rxcnt_q;

    case (state)
      IDLE: begin
        if (bus.CMDSTART && !bus.SPIBUSY) begin
          state_nxt = REQ;
          busy_d    = 1'b1;
          start_d   = 1'b1;
          rxcnt_d   = '0;
          wdog_d    = '0;
        end
      end
      REQ, RUN: begin
        if (wdog_q != '1) begin
          wdog_d = wdog_q + TOUT_WIDTH'(1);
        end
        if (wd_hit) begin
          state_nxt = IDLE;
          start_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else if (state == REQ) begin
          if (bus.SPIBUSY) begin
            state_nxt = RUN;
            start_d   = 1'b0;
          end
        end else if (!bus.SPIBUSY) begin
          state_nxt = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_d    = 1'b0;
        start_d   = 1'b0;
      end
    endcase

    // RX capture is independent of the command state.
    if (bus.RXVALID) begin
      rxcnt_d = {1'b0, bus.RXDPT} + 5'd1;
    end
  end

  // Host writes are only taken while no command is running, so the engine
  // always sees a stable TX image for the whole transfer.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      for (int i = 0; i < 16; i++) begin
        txbuf[i] <= '0;
      end
    end else if (bus.TXWE && !busy_q) begin
      txbuf[bus.TXWADDR] <= bus.TXWDATA;
    end
  end

  // Read and write in the same block give read-before-write on a collision.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      for (int i = 0; i < 16; i++) begin
        rxbuf[i] <= '0;
      end
      rxrdata_q <= '0;
    end else begin
      rxrdata_q <= rxbuf[bus.RXRADDR];
      if (bus.RXVALID) begin
        rxbuf[bus.RXDPT] <= bus.RXDATA;
      end
    end
  end

  assign bus.TXDATA   = txbuf[bus.TXDPT];
  assign bus.RXRDATA  = rxrdata_q;
  assign bus.RXCNT    = rxcnt_q;
  assign bus.CMDBUSY  = busy_q;
  assign bus.CMDDONE  = done_q;
  assign bus.CMDERR   = err_q;
  assign bus.SPISTART = start_q;

endmodule

// File: tb/tb_sc_spi_xfer_ctrl.sv
// tb/tb_sc_spi_xfer_ctrl.sv - directed vector bench for sc_spi_xfer_ctrl
module tb_sc_spi_xfer_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sc_spi_xfer_ctrl_if #(.TOUT_WIDTH(16)) bus ();

  sc_spi_xfer_ctrl #(.TOUT_WIDTH(16)) dut (
    .SPICLK  (clk),
    .SYSRSTB (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        txwe;
    logic [3:0]  txwaddr;
    logic [31:0] txwdata;
    logic [3:0]  txdpt;
    logic        cmdstart;
    logic        spibusy;
    logic        doneclr;
    logic        rxvalid;
    logic [3:0]  rxdpt;
    logic [31:0] rxdata;
    logic [3:0]  rxraddr;
    logic [31:0] e_txdata;
    logic [31:0] e_rxrdata;
    logic [4:0]  e_rxcnt;
    logic        e_busy;
    logic        e_start;
    logic        e_done;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.TXWE     = 1'b0;
    bus.TXWADDR  = '0;
    bus.TXWDATA  = '0;
    bus.CMDSTART = 1'b0;
    bus.DONECLR  = 1'b0;
    bus.RXVALID  = 1'b0;
    bus.RXDPT    = '0;
    bus.RXDATA   = '0;
  endtask

  initial begin
    int hi;
    logic txok;

    total = 0;
    bad   = 0;

    // in: txwe addr data txdpt start busy clr rxv rxdpt rxdata raddr | exp: txdata rxrdata rxcnt busy start done err
    vecs[0]  = '{1, 0, 32'hA5A5_1234, 0, 0, 0, 0, 0, 0, 0,     0, 32'hA5A5_1234, 0,     0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 32'h0BAD_F00D, 1, 0, 0, 0, 0, 0, 0,     0, 32'h0BAD_F00D, 0,     0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0,            0, 1, 0, 0, 0, 0, 0,     0, 32'hA5A5_1234, 0,     0, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 0,            0, 0, 0, 0, 0, 0, 0,     0, 32'hA5A5_1234, 0,     0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 0,            0, 0, 1, 0, 0, 0, 0,     0, 32'hA5A5_1234, 0,     0, 1, 0, 0, 0};
    vecs[5]  = '{1, 0, 32'hFFFF_FFFF, 0, 1, 1, 0, 0, 0, 0,     0, 32'hA5A5_1234, 0,     0, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 0,            1, 0, 1, 0, 1, 0, 32'h11, 0, 32'h0BAD_F00D, 0,     1, 1, 0, 0, 0};
    vecs[7]  = '{0, 0, 0,            0, 0, 1, 0, 1, 1, 32'h22, 0, 32'hA5A5_1234, 32'h11, 2, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 0,            0, 0, 1, 0, 1, 2, 32'h33, 1, 32'hA5A5_1234, 32'h22, 3, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 0,            0, 0, 1, 0, 1, 1, 32'h44, 1, 32'hA5A5_1234, 32'h22, 2, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 0,            0, 0, 1, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 2, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 0,            0, 0, 1, 0, 0, 0, 0,     1, 32'hA5A5_1234, 32'h44, 2, 1, 0, 0, 0};
    vecs[12] = '{0, 0, 0,            0, 0, 0, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 2, 0, 0, 1, 0};
    vecs[13] = '{0, 0, 0,            0, 0, 0, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 2, 0, 0, 1, 0};
    vecs[14] = '{0, 0, 0,            0, 0, 0, 1, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 2, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 0,            0, 1, 0, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 0, 1, 1, 0, 0};
    vecs[16] = '{0, 0, 0,            0, 0, 1, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 0, 1, 0, 0, 0};
    vecs[17] = '{0, 0, 0,            0, 0, 0, 1, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 0, 0, 0, 1, 0};
    vecs[18] = '{0, 0, 0,            0, 1, 0, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 0, 1, 1, 1, 0};
    vecs[19] = '{0, 0, 0,            0, 0, 1, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 0, 1, 0, 1, 0};
    vecs[20] = '{0, 0, 0,            0, 0, 0, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 0, 0, 0, 1, 0};
    vecs[21] = '{0, 0, 0,            0, 1, 1, 0, 0, 0, 0,     2, 32'hA5A5_1234, 32'h33, 0, 0, 0, 1, 0};

    // Reset state
    rst_n       = 1'b0;
    idle_inputs();
    bus.TOUTVAL = '0;
    bus.SPIBUSY = 1'b0;
    bus.TXDPT   = '0;
    bus.RXRADDR = '0;
    tick();
    tick();
    chk("rst_busy",    {31'd0, bus.CMDBUSY},  32'd0);
    chk("rst_done",    {31'd0, bus.CMDDONE},  32'd0);
    chk("rst_err",     {31'd0, bus.CMDERR},   32'd0);
    chk("rst_start",   {31'd0, bus.SPISTART}, 32'd0);
    chk("rst_rxrdata", bus.RXRDATA,           32'd0);
    chk("rst_rxcnt",   {27'd0, bus.RXCNT},    32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors, one clock edge per row, outputs checked after the edge
    for (int i = 0; i < NVEC; i++) begin
      bus.TXWE     = vecs[i].txwe;
      bus.TXWADDR  = vecs[i].txwaddr;
      bus.TXWDATA  = vecs[i].txwdata;
      bus.TXDPT    = vecs[i].txdpt;
      bus.CMDSTART = vecs[i].cmdstart;
      bus.SPIBUSY  = vecs[i].spibusy;
      bus.DONECLR  = vecs[i].doneclr;
      bus.RXVALID  = vecs[i].rxvalid;
      bus.RXDPT    = vecs[i].rxdpt;
      bus.RXDATA   = vecs[i].rxdata;
      bus.RXRADDR  = vecs[i].rxraddr;
      tick();
      chk($sformatf("vec%0d_txdata", i),  bus.TXDATA,             vecs[i].e_txdata);
      chk($sformatf("vec%0d_rxrdata", i), bus.RXRDATA,            vecs[i].e_rxrdata);
      chk($sformatf("vec%0d_rxcnt", i),   {27'd0, bus.RXCNT},     {27'd0, vecs[i].e_rxcnt});
      chk($sformatf("vec%0d_busy", i),    {31'd0, bus.CMDBUSY},   {31'd0, vecs[i].e_busy});
      chk($sformatf("vec%0d_start", i),   {31'd0, bus.SPISTART},  {31'd0, vecs[i].e_start});
      chk($sformatf("vec%0d_done", i),    {31'd0, bus.CMDDONE},   {31'd0, vecs[i].e_done});
      chk($sformatf("vec%0d_err", i),     {31'd0, bus.CMDERR},    {31'd0, vecs[i].e_err});
    end
    idle_inputs();
    bus.SPIBUSY = 1'b0;
    bus.TXDPT   = '0;

    // Normal command with a 40-cycle engine busy window and TXDPT stepping 0 -> 1
    bus.DONECLR = 1'b1;
    tick();
    bus.DONECLR  = 1'b0;
    bus.CMDSTART = 1'b1;
    tick();
    bus.CMDSTART = 1'b0;
    hi = bus.SPISTART ? 1 : 0;
    tick();
    if (bus.SPISTART) hi++;
    txok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.SPIBUSY = 1'b1;
      bus.TXDPT   = (i < 20) ? 4'd0 : 4'd1;
      tick();
      if (bus.SPISTART) hi++;
      if (bus.TXDATA !== ((i < 20) ? 32'hA5A5_1234 : 32'h0BAD_F00D)) txok = 1'b0;
    end
    chk("norm_txdata_track", {31'd0, txok}, 32'd1);
    chk("norm_start_cycles", hi, 2);
    chk("norm_busy_during",  {31'd0, bus.CMDBUSY}, 32'd1);
    bus.SPIBUSY = 1'b0;
    tick();
    chk("norm_done", {31'd0, bus.CMDDONE}, 32'd1);
    chk("norm_err",  {31'd0, bus.CMDERR},  32'd0);
    chk("norm_busy", {31'd0, bus.CMDBUSY}, 32'd0);

    // Watchdog, TOUTVAL = 8, engine never answers
    bus.TOUTVAL = 16'd8;
    bus.DONECLR = 1'b1;
    tick();
    bus.DONECLR  = 1'b0;
    bus.CMDSTART = 1'b1;
    tick();
    bus.CMDSTART = 1'b0;
    hi = bus.SPISTART ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.SPISTART) break;
      tick();
      if (bus.SPISTART) hi++;
    end
    chk("wd8_start_cycles", hi, 8);
    chk("wd8_err",  {31'd0, bus.CMDERR},  32'd1);
    chk("wd8_done", {31'd0, bus.CMDDONE}, 32'd1);
    chk("wd8_busy", {31'd0, bus.CMDBUSY}, 32'd0);

    // Timeout wins over a completion in the same cycle (TOUTVAL = 3)
    bus.TOUTVAL = 16'd3;
    bus.DONECLR = 1'b1;
    tick();
    bus.DONECLR  = 1'b0;
    bus.CMDSTART = 1'b1;
    tick();
    bus.CMDSTART = 1'b0;
    bus.SPIBUSY  = 1'b1;
    tick();
    tick();
    chk("wdprio_pre_err", {31'd0, bus.CMDERR}, 32'd0);
    bus.SPIBUSY = 1'b0;
    tick();
    chk("wdprio_err",  {31'd0, bus.CMDERR},  32'd1);
    chk("wdprio_done", {31'd0, bus.CMDDONE}, 32'd1);
    chk("wdprio_busy", {31'd0, bus.CMDBUSY}, 32'd0);

    // TOUTVAL = 0: stays in REQ indefinitely
    bus.TOUTVAL = '0;
    bus.DONECLR = 1'b1;
    tick();
    bus.DONECLR  = 1'b0;
    bus.CMDSTART = 1'b1;
    tick();
    bus.CMDSTART = 1'b0;
    repeat (100) tick();
    chk("wd0_start", {31'd0, bus.SPISTART}, 32'd1);
    chk("wd0_busy",  {31'd0, bus.CMDBUSY},  32'd1);
    chk("wd0_err",   {31'd0, bus.CMDERR},   32'd0);

    // Enter RUN, then reset asynchronously between clock edges
    bus.SPIBUSY = 1'b1;
    tick();
    chk("prerst_run_busy", {31'd0, bus.CMDBUSY}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",    {31'd0, bus.CMDBUSY},  32'd0);
    chk("arst_done",    {31'd0, bus.CMDDONE},  32'd0);
    chk("arst_err",     {31'd0, bus.CMDERR},   32'd0);
    chk("arst_start",   {31'd0, bus.SPISTART}, 32'd0);
    chk("arst_rxrdata", bus.RXRDATA,           32'd0);
    chk("arst_rxcnt",   {27'd0, bus.RXCNT},    32'd0);
    txok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.TXDPT = 4'(i);
      #1;
      if (bus.TXDATA !== 32'd0) txok = 1'b0;
    end
    chk("arst_txdata_all_zero", {31'd0, txok}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
